// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encodings, error codes and the
// per-state output decode.
package prog_loader_pkg;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_CNT_HI = 4'd1;
    localparam logic [3:0] ST_CNT_LO = 4'd2;
    localparam logic [3:0] ST_DAT_HI = 4'd3;
    localparam logic [3:0] ST_DAT_LO = 4'd4;
    localparam logic [3:0] ST_WRITE  = 4'd5;
    localparam logic [3:0] ST_CSUM   = 4'd6;
    localparam logic [3:0] ST_RUN    = 4'd7;
    localparam logic [3:0] ST_ERR    = 4'd8;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE = 2'd0;
    localparam err_code_t ERR_LEN  = 2'd1;
    localparam err_code_t ERR_CSUM = 2'd2;
    localparam err_code_t ERR_TMO  = 2'd3;

    // Frame on the wire: COUNT_HI COUNT_LO {W_HI W_LO} x N CSUM, big-endian.
    typedef struct packed {
        logic rx_ready;
        logic busy;
        logic work;
        logic im_we;
    } st_out_t;

    function automatic st_out_t decode_state(input logic [3:0] st);
        st_out_t o;
        o          = '0;
        o.rx_ready = (st == ST_CNT_HI) || (st == ST_CNT_LO) || (st == ST_DAT_HI) ||
                     (st == ST_DAT_LO) || (st == ST_CSUM);
        o.busy     = (st >= ST_CNT_HI) && (st <= ST_CSUM);
        o.work     = (st == ST_RUN);
        o.im_we    = (st == ST_WRITE);
        return o;
    endfunction

endpackage

// File: rtl/prog_loader_byte_timer.sv
// Idle-cycle counter for the loader: o_expired flags the cycle in which the TIMEOUT-th
// consecutive enabled cycle completes. TIMEOUT of 0 disables it.
module prog_loader_byte_timer #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    if (TIMEOUT == 0) begin : g_off
        assign o_expired = 1'b0;
    end else begin : g_on
        localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

        logic [CNT_W-1:0] r_cnt;

        assign o_expired = i_en && (r_cnt == CNT_LAST);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt <= '0;
            end else if (i_clr) begin
                r_cnt <= '0;
            end else if (i_en && !o_expired) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses a length/data/checksum byte frame into 16-bit instruction-memory
// writes, then enables the core; also owns the core's run/halt control.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_halt,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    output logic              o_im_we,
    output logic [ADDR_W-1:0] o_im_addr,
    output logic [15:0]       o_im_wdata,
    output logic              o_work,
    output logic              o_busy,
    output logic              o_err,
    output logic [1:0]        o_err_code
);

    logic [3:0]        r_state,     w_state_d;
    logic [7:0]        r_hi,        w_hi_d;
    logic [7:0]        r_csum,      w_csum_d;
    logic [ADDR_W-1:0] r_addr,      w_addr_d;
    logic [15:0]       r_remain,    w_remain_d;
    logic [ADDR_W-1:0] r_im_addr,   w_im_addr_d;
    logic [15:0]       r_im_wdata,  w_im_wdata_d;
    logic              r_err,       w_err_d;
    err_code_t         r_err_code,  w_err_code_d;
    st_out_t           r_out;

    logic        w_xfer;
    logic        w_expired;
    logic        w_can_start;
    logic        w_tmr_clr;
    logic        w_tmr_en;
    logic [15:0] w_count;

    assign w_xfer      = i_rx_valid & r_out.rx_ready;
    assign w_count     = {r_hi, i_rx_data};
    assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_ERR);
    assign w_tmr_clr   = w_xfer | ~r_out.rx_ready;
    assign w_tmr_en    = r_out.rx_ready & ~w_xfer;

    prog_loader_byte_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_byte_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_d     = r_state;
        w_hi_d        = r_hi;
        w_csum_d      = r_csum;
        w_addr_d      = r_addr;
        w_remain_d    = r_remain;
        w_im_addr_d   = r_im_addr;
        w_im_wdata_d  = r_im_wdata;
        w_err_d       = r_err;
        w_err_code_d  = r_err_code;

        if (i_halt) begin
            w_state_d = ST_IDLE;
        end else if (i_start && w_can_start) begin
            w_state_d    = ST_CNT_HI;
            w_err_d      = 1'b0;
            w_err_code_d = ERR_NONE;
            w_addr_d     = '0;
            w_csum_d     = '0;
        end else begin
            case (r_state)
                ST_CNT_HI: begin
                    if (w_xfer) begin
                        w_hi_d    = i_rx_data;
                        w_state_d = ST_CNT_LO;
                    end
                end
                ST_CNT_LO: begin
                    if (w_xfer) begin
                        if (w_count == 16'd0 || 32'(w_count) > DEPTH) begin
                            w_state_d    = ST_ERR;
                            w_err_d      = 1'b1;
                            w_err_code_d = ERR_LEN;
                        end else begin
                            w_remain_d = w_count;
                            w_state_d  = ST_DAT_HI;
                        end
                    end
                end
                ST_DAT_HI: begin
                    if (w_xfer) begin
                        w_hi_d    = i_rx_data;
                        w_csum_d  = r_csum ^ i_rx_data;
                        w_state_d = ST_DAT_LO;
                    end
                end
                ST_DAT_LO: begin
                    if (w_xfer) begin
                        w_csum_d     = r_csum ^ i_rx_data;
                        w_im_addr_d  = r_addr;
                        w_im_wdata_d = {r_hi, i_rx_data};
                        w_state_d    = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    w_addr_d   = r_addr + ADDR_W'(1);
                    w_remain_d = r_remain - 16'd1;
                    w_state_d  = (r_remain == 16'd1) ? ST_CSUM : ST_DAT_HI;
                end
                ST_CSUM: begin
                    if (w_xfer) begin
                        if (i_rx_data == r_csum) begin
                            w_state_d = ST_RUN;
                        end else begin
                            w_state_d    = ST_ERR;
                            w_err_d      = 1'b1;
                            w_err_code_d = ERR_CSUM;
                        end
                    end
                end
                default: ;
            endcase

            // Only asserted in byte-accepting states on a cycle without a transfer.
            if (w_expired) begin
                w_state_d    = ST_ERR;
                w_err_d      = 1'b1;
                w_err_code_d = ERR_TMO;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_hi       <= '0;
            r_csum     <= '0;
            r_addr     <= '0;
            r_remain   <= '0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_out      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_hi       <= w_hi_d;
            r_csum     <= w_csum_d;
            r_addr     <= w_addr_d;
            r_remain   <= w_remain_d;
            r_im_addr  <= w_im_addr_d;
            r_im_wdata <= w_im_wdata_d;
            r_err      <= w_err_d;
            r_err_code <= w_err_code_d;
            r_out      <= decode_state(w_state_d);
        end
    end

    assign o_rx_ready = r_out.rx_ready;
    assign o_busy     = r_out.busy;
    assign o_work     = r_out.work;
    assign o_im_we    = r_out.im_we;
    assign o_im_addr  = r_im_addr;
    assign o_im_wdata = r_im_wdata;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table vectors, hand-written corner sequences and
// randomized frames against a frame-level reference model.
module tb_prog_loader;

    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 20;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              halt     = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [15:0]       im_wdata;
    logic              work;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;

    always #5 clk = ~clk;

    prog_loader #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_halt     (halt),
        .i_rx_valid (rx_valid),
        .i_rx_data  (rx_data),
        .o_rx_ready (rx_ready),
        .o_im_we    (im_we),
        .o_im_addr  (im_addr),
        .o_im_wdata (im_wdata),
        .o_work     (work),
        .o_busy     (busy),
        .o_err      (err),
        .o_err_code (err_code)
    );

    // Write log, owned by the monitor only.
    int                wr_cnt  = 0;
    int                overlap = 0;
    logic [ADDR_W-1:0] wr_addr [4096];
    logic [15:0]       wr_data [4096];

    always @(negedge clk) begin
        if (im_we) begin
            if (wr_cnt < 4096) begin
                wr_addr[wr_cnt] = im_addr;
                wr_data[wr_cnt] = im_wdata;
            end
            wr_cnt = wr_cnt + 1;
            if (rx_ready) overlap = overlap + 1;
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_words [$];
    logic        m_work;
    logic        m_err;
    logic [1:0]  m_code;

    typedef struct {
        logic [15:0] count;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [7:0]  csum;
        logic        e_work;
        logic        e_err;
        logic [1:0]  e_code;
    } vec_t;

    vec_t vt [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep, output bit ok);
        int guard;
        guard    = 0;
        ok       = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!ok && guard < 50) begin
            if (rx_ready) ok = 1'b1;
            tick();
            guard++;
        end
        if (!keep) rx_valid = 1'b0;
        if (!ok) check("byte_accept", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] f[$], input int gap_max, input bit b2b);
        bit ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < f.size(); i++) begin
            if (!b2b) idle($urandom_range(0, gap_max));
            send_byte(f[i], b2b, ok);
            if (!ok) break;
        end
        rx_valid = 1'b0;
    endtask

    // Frame-level reference: what a correct loader does with a whole byte frame.
    function automatic void model_frame(input logic [7:0] f[$]);
        int unsigned n;
        logic [7:0]  x;
        exp_words.delete();
        n = {16'd0, f[0], f[1]};
        if (n == 0 || n > DEPTH) begin
            m_work = 1'b0;
            m_err  = 1'b1;
            m_code = 2'd1;
            return;
        end
        x = 8'h00;
        for (int unsigned i = 0; i < n; i++) begin
            exp_words.push_back({f[2 + 2 * i], f[3 + 2 * i]});
            x = x ^ f[2 + 2 * i] ^ f[3 + 2 * i];
        end
        m_work = (f[2 + 2 * n] == x);
        m_err  = !m_work;
        m_code = m_work ? 2'd0 : 2'd2;
    endfunction

    task automatic check_result(input string tag, input int base, input logic e_work,
                                input logic e_err, input logic [1:0] e_code);
        int n;
        n = wr_cnt - base;
        check($sformatf("%s nwrites", tag), n, exp_words.size());
        for (int i = 0; i < exp_words.size() && i < n; i++) begin
            check($sformatf("%s addr%0d", tag, i), 32'(wr_addr[base + i]), i);
            check($sformatf("%s data%0d", tag, i), 32'(wr_data[base + i]), 32'(exp_words[i]));
        end
        check($sformatf("%s work", tag), 32'(work), 32'(e_work));
        check($sformatf("%s err", tag), 32'(err), 32'(e_err));
        check($sformatf("%s err_code", tag), 32'(err_code), 32'(e_code));
        check($sformatf("%s busy", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f [$];
        int         base;
        int         cyc;
        bit         ok;

        vt[0] = '{16'd3, 16'h1234, 16'hABCD, 16'h0F0F, 8'h40, 1'b1, 1'b0, 2'd0};
        vt[1] = '{16'd3, 16'h1234, 16'hABCD, 16'h0F0F, 8'h00, 1'b0, 1'b1, 2'd2};
        vt[2] = '{16'd3, 16'h1234, 16'hABCD, 16'h0F0F, 8'h17, 1'b0, 1'b1, 2'd2};
        vt[3] = '{16'h0000, 16'h0, 16'h0, 16'h0, 8'h00, 1'b0, 1'b1, 2'd1};
        vt[4] = '{16'h0101, 16'h0, 16'h0, 16'h0, 8'h00, 1'b0, 1'b1, 2'd1};
        vt[5] = '{16'd1, 16'hBEEF, 16'h0, 16'h0, 8'h51, 1'b1, 1'b0, 2'd0};
        vt[6] = '{16'd2, 16'h0000, 16'hFFFF, 16'h0, 8'h00, 1'b1, 1'b0, 2'd0};

        #1;
        check("reset outputs",
              {2'b0, rx_ready, im_we, im_addr, im_wdata, work, busy, err, err_code}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("idle outputs",
              {2'b0, rx_ready, im_we, im_addr, im_wdata, work, busy, err, err_code}, 32'd0);

        // Table vectors.
        for (int v = 0; v < 7; v++) begin
            logic [15:0] w [3];
            w[0] = vt[v].w0;
            w[1] = vt[v].w1;
            w[2] = vt[v].w2;
            f.delete();
            exp_words.delete();
            f.push_back(vt[v].count[15:8]);
            f.push_back(vt[v].count[7:0]);
            if (vt[v].e_code != 2'd1) begin
                for (int i = 0; i < int'(vt[v].count); i++) begin
                    f.push_back(w[i][15:8]);
                    f.push_back(w[i][7:0]);
                    exp_words.push_back(w[i]);
                end
                f.push_back(vt[v].csum);
            end
            base = wr_cnt;
            run_frame(f, 0, 1'b0);
            if (vt[v].e_code == 2'd1) begin
                check($sformatf("vec%0d code after cnt_lo", v), 32'(err_code), 32'd1);
            end
            tick();
            tick();
            check_result($sformatf("vec%0d", v), base, vt[v].e_work, vt[v].e_err, vt[v].e_code);
        end

        // Idle timeout: err_code 3 exactly TIMEOUT cycles after the last accepted byte.
        base = wr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'h02, 1'b0, ok);
        send_byte(8'h11, 1'b0, ok);
        cyc = 0;
        while (err_code != 2'd3 && cyc < 60) begin
            tick();
            cyc++;
        end
        check("timeout cycles", cyc, TIMEOUT);
        check("timeout err", 32'(err), 32'd1);
        check("timeout writes", wr_cnt - base, 32'd0);

        // Halt from RUN.
        f = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
        run_frame(f, 0, 1'b0);
        tick();
        check("run work", 32'(work), 32'd1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt work", {busy, work, err}, 32'd0);

        // Start alone in RUN reloads.
        run_frame(f, 0, 1'b0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("reload work/busy", {work, busy}, 32'b01);

        // start+halt together: halt wins.
        start = 1'b1;
        halt  = 1'b1;
        tick();
        start = 1'b0;
        halt  = 1'b0;
        tick();
        check("start+halt idle", {work, busy, rx_ready}, 32'd0);

        // Halt mid-load: no further writes, err not set.
        base = wr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'h03, 1'b0, ok);
        send_byte(8'h12, 1'b0, ok);
        send_byte(8'h34, 1'b0, ok);
        send_byte(8'hAB, 1'b0, ok);
        halt = 1'b1;
        tick();
        halt     = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hCD;
        repeat (6) tick();
        rx_valid = 1'b0;
        check("halt load writes", wr_cnt - base, 32'd1);
        check("halt load flags", {busy, err, work, rx_ready}, 32'd0);

        // Back-to-back bytes with rx_valid held high.
        f = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        model_frame(f);
        base = wr_cnt;
        run_frame(f, 0, 1'b1);
        tick();
        check_result("b2b", base, m_work, m_err, m_code);

        // Randomized frames against the reference model.
        for (int t = 0; t < 25; t++) begin
            int unsigned n;
            logic [7:0]  x;
            f.delete();
            if ($urandom_range(0, 5) == 0) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : 257 + $urandom_range(0, 4000);
                f.push_back(8'(n >> 8));
                f.push_back(8'(n));
            end else begin
                n = $urandom_range(1, 6);
                f.push_back(8'(n >> 8));
                f.push_back(8'(n));
                x = 8'h00;
                for (int unsigned i = 0; i < 2 * n; i++) begin
                    f.push_back(8'($urandom));
                    x = x ^ f[f.size() - 1];
                end
                f.push_back(($urandom_range(0, 2) == 0) ? 8'($urandom) : x);
            end
            model_frame(f);
            base = wr_cnt;
            run_frame(f, 4, $urandom_range(0, 1) == 1);
            tick();
            tick();
            check_result($sformatf("rnd%0d", t), base, m_work, m_err, m_code);
        end

        check("rx_ready during write", overlap, 32'd0);

        // Reset mid-frame: outputs drop at once, no write completes.
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h00, 1'b1, ok);
        send_byte(8'h04, 1'b1, ok);
        send_byte(8'h11, 1'b1, ok);
        rx_data = 8'h22;
        base    = wr_cnt;
        rst_n   = 1'b0;
        #1;
        check("async reset outputs",
              {2'b0, rx_ready, im_we, im_addr, im_wdata, work, busy, err, err_code}, 32'd0);
        repeat (3) tick();
        rx_valid = 1'b0;
        check("reset writes", wr_cnt - base, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post reset busy", {busy, work}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
